rstseq_sonata: RTL



---
 rtl/rstseq_sonata.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/rstseq_sonata.sv
// rstseq_sonata: reset sequencer for the clk_sys domain.
// Synchronises PLL lock and board reset, waits for a stable window, then
// releases NumDomains active-low resets in order (domain 0 first), one every
// StageGap cycles. Re-sequences on lock loss, board reset, or a software
// request; lock loss after sequencing has started is flagged sticky.
//
// Ports:
//   clk_sys          system clock
//   rst_sys          synchronous active-high reset
//   pll_locked_i     asynchronous PLL lock, active high
//   ext_rst_ni       asynchronous board reset, active low
//   sw_rst_req_i     one-cycle requests; bit k resets domain k and above
//   lock_lost_clr_i  clears lock_lost_o
//   rst_n_o          per-domain active-low resets, registered
//   all_released_o   high only in RUN
//   lock_lost_o      sticky lock-loss flag
//   state_o          0 WAIT_LOCK, 1 RELEASE, 2 RUN, 3 HOLD
//
// state     | meaning
// ----------+----------------------------------------------------------
// WAIT_LOCK | all domains held; timing how long lock and board reset are good
// RELEASE   | releasing domains idx..NumDomains-1, one per StageGap cycles
// RUN       | all domains released; accepting software requests
// HOLD      | requested domains held for HoldCycles before re-release

module rstseq_sonata #(
   parameter int NumDomains       = 4,
   parameter int LockStableCycles = 1024,
   parameter int StageGap         = 16,
   parameter int HoldCycles       = 8,
   localparam int MaxLg = (LockStableCycles > StageGap) ? LockStableCycles : StageGap,
   localparam int MaxCnt = (MaxLg > HoldCycles) ? MaxLg : HoldCycles,
   localparam int CntW = $clog2(MaxCnt + 1)
) (
   input  logic                  clk_sys,
   input  logic                  rst_sys,
   input  logic                  pll_locked_i,
   input  logic                  ext_rst_ni,
   input  logic [NumDomains-1:0] sw_rst_req_i,
   input  logic                  lock_lost_clr_i,
   output logic [NumDomains-1:0] rst_n_o,
   output logic                  all_released_o,
   output logic                  lock_lost_o,
   output logic [1:0]            state_o
);

   localparam int IdxW = (NumDomains > 1) ? $clog2(NumDomains) : 1;

   // Timers are down-counters loaded with (period-1) and expiring at zero.
   localparam logic [CntW-1:0] LockLoad = CntW'(LockStableCycles - 1);
   localparam logic [CntW-1:0] GapLoad  = CntW'(StageGap - 1);
   localparam logic [CntW-1:0] HoldLoad = CntW'(HoldCycles - 1);
   localparam logic [IdxW-1:0] LastIdx  = IdxW'(NumDomains - 1);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      RELEASE   = 2'd1,
      RUN       = 2'd2,
      HOLD      = 2'd3
   } state_t;

   state_t                state_q;
   logic [CntW-1:0]       cnt_q;
   logic [IdxW-1:0]       idx_q;
   logic [1:0]            lock_sync_q;
   logic [1:0]            ext_sync_q;
   logic                  lock_s;
   logic                  ext_s;
   logic                  good;
   logic [IdxW-1:0]       req_idx;
   logic [NumDomains-1:0] keep_mask;
   logic [NumDomains-1:0] rel_mask;

   // Synchroniser flops reset to 0 so both inputs read as bad under reset.
   always_ff @(posedge clk_sys) begin
      if (rst_sys) begin
         lock_sync_q <= 2'b00;
         ext_sync_q  <= 2'b00;
      end else begin
         lock_sync_q <= {lock_sync_q[0], pll_locked_i};
         ext_sync_q  <= {ext_sync_q[0], ext_rst_ni};
      end
   end

   assign lock_s = lock_sync_q[1];
   assign ext_s  = ext_sync_q[1];
   assign good   = lock_s & ext_s;

   // Lowest requested domain, and the mask of domains below it that survive.
   always_comb begin
      req_idx   = '0;
      keep_mask = '0;
      for (int i = NumDomains - 1; i >= 0; i--) begin
         if (sw_rst_req_i[i]) req_idx = IdxW'(i);
      end
      for (int i = 0; i < NumDomains; i++) begin
         keep_mask[i] = (i < int'(req_idx));
      end
   end

   // Current outputs plus the one domain being released this stage.
   always_comb begin
      rel_mask = rst_n_o;
      for (int i = 0; i < NumDomains; i++) begin
         if (i == int'(idx_q)) rel_mask[i] = 1'b1;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (rst_sys) begin
         state_q        <= WAIT_LOCK;
         cnt_q          <= '0;
         idx_q          <= '0;
         rst_n_o        <= '0;
         all_released_o <= 1'b0;
         lock_lost_o    <= 1'b0;
      end else begin
         // A set of lock_lost_o further down overrides this clear.
         if (lock_lost_clr_i) lock_lost_o <= 1'b0;

         if (state_q != WAIT_LOCK && !good) begin
            state_q        <= WAIT_LOCK;
            cnt_q          <= LockLoad;
            idx_q          <= '0;
            rst_n_o        <= '0;
            all_released_o <= 1'b0;
            if (!lock_s) lock_lost_o <= 1'b1;
         end else begin
            case (state_q)
               WAIT_LOCK: begin
                  if (!good) begin
                     cnt_q <= LockLoad;
                  end else if (cnt_q == '0) begin
                     state_q <= RELEASE;
                     cnt_q   <= GapLoad;
                     idx_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end

               RELEASE: begin
                  if (cnt_q == '0) begin
                     rst_n_o <= rel_mask;
                     cnt_q   <= GapLoad;
                     if (idx_q == LastIdx) begin
                        state_q        <= RUN;
                        all_released_o <= 1'b1;
                     end else begin
                        idx_q <= idx_q + 1'b1;
                     end
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end

               RUN: begin
                  if (|sw_rst_req_i) begin
                     rst_n_o        <= rst_n_o & keep_mask;
                     idx_q          <= req_idx;
                     cnt_q          <= HoldLoad;
                     state_q        <= HOLD;
                     all_released_o <= 1'b0;
                  end
               end

               HOLD: begin
                  if (cnt_q == '0) begin
                     state_q <= RELEASE;
                     cnt_q   <= GapLoad;
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end

               default: begin
                  state_q <= WAIT_LOCK;
                  cnt_q   <= LockLoad;
                  rst_n_o <= '0;
               end
            endcase
         end
      end
   end

   assign state_o = state_q;

endmodule
